// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-port (fetch/data) arbiter onto a shared cache port; ARB_DPRIO_EN selects fixed D priority
module cache_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int HOLD_CYC = 2,
    parameter int TMO_CYC  = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic [DATA_W-1:0] I_DATA,
    output logic              I_ACK,
    output logic              I_ERR,
    input  logic              D_RREQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_DIN,
    output logic [DATA_W-1:0] D_DOUT,
    output logic              D_ACK,
    output logic              D_ERR,
    output logic [ADDR_W-1:0] C_ADDR,
    output logic [DATA_W-1:0] C_DIN,
    output logic              C_WE,
    output logic              C_RREQ,
    input  logic [DATA_W-1:0] C_DOUT,
    input  logic              C_RDY
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [3:0]  HOLD_N = 4'(HOLD_CYC);
    localparam logic [15:0] TMO_N  = 16'(TMO_CYC);

    state_t            state_q, state_d;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic [15:0]       tmo_cnt_q, tmo_cnt_d;
    logic [15:0]       tmo_inc;
    logic              gnt_d_q, gnt_d_d;     // 1: current transaction belongs to the D port
    logic              is_wr_q, is_wr_d;
    logic              c_we_q, c_we_d, c_rreq_q, c_rreq_d;
    logic [ADDR_W-1:0] c_addr_q, c_addr_d;
    logic [DATA_W-1:0] c_din_q, c_din_d;
    logic [DATA_W-1:0] i_data_q, i_data_d, d_dout_q, d_dout_d;
    logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic              d_pend;
    logic              pick_d;

    assign d_pend  = D_RREQ | D_WE;
    assign tmo_inc = tmo_cnt_q + 16'd1;

`ifdef ARB_DPRIO_EN
    assign pick_d = d_pend;
`else
    logic last_d_q, last_d_d;                // 1: D was granted last, so I wins a tie next
    assign pick_d = d_pend & (~I_REQ | ~last_d_q);
`endif

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/RESP sequence
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        gnt_d_d    = gnt_d_q;
        is_wr_d    = is_wr_q;
        c_we_d     = c_we_q;
        c_rreq_d   = c_rreq_q;
        c_addr_d   = c_addr_q;
        c_din_d    = c_din_q;
        i_data_d   = i_data_q;
        d_dout_d   = d_dout_q;
        i_ack_d    = i_ack_q;
        i_err_d    = i_err_q;
        d_ack_d    = d_ack_q;
        d_err_d    = d_err_q;
`ifndef ARB_DPRIO_EN
        last_d_d   = last_d_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (I_REQ || d_pend) begin
                    gnt_d_d    = pick_d;
                    is_wr_d    = pick_d & D_WE;   // write wins when D_WE and D_RREQ are both set
                    c_we_d     = pick_d & D_WE;
                    c_rreq_d   = ~(pick_d & D_WE);
                    c_addr_d   = pick_d ? D_ADDR : I_ADDR;
                    if (pick_d) begin
                        c_din_d = D_DIN;
                    end
                    hold_cnt_d = 4'd1;
`ifndef ARB_DPRIO_EN
                    last_d_d   = pick_d;
`endif
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hold_cnt_q == HOLD_N) begin
                    c_we_d    = 1'b0;
                    c_rreq_d  = 1'b0;
                    tmo_cnt_d = 16'd0;
                    state_d   = S_WAIT;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (C_RDY) begin
                    if (!is_wr_q) begin
                        if (gnt_d_q) d_dout_d = C_DOUT;
                        else         i_data_d = C_DOUT;
                    end
                    d_ack_d = gnt_d_q;
                    i_ack_d = ~gnt_d_q;
                    state_d = S_RESP;
                end else if (tmo_inc == TMO_N) begin
                    d_ack_d = gnt_d_q;
                    i_ack_d = ~gnt_d_q;
                    d_err_d = gnt_d_q;
                    i_err_d = ~gnt_d_q;
                    state_d = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_inc;
                end
            end
            S_RESP: begin
                i_ack_d    = 1'b0;
                d_ack_d    = 1'b0;
                i_err_d    = 1'b0;
                d_err_d    = 1'b0;
                tmo_cnt_d  = 16'd0;
                hold_cnt_d = 4'd0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= 4'd0;
            tmo_cnt_q  <= 16'd0;
            gnt_d_q    <= 1'b0;
            is_wr_q    <= 1'b0;
            c_we_q     <= 1'b0;
            c_rreq_q   <= 1'b0;
            c_addr_q   <= '0;
            c_din_q    <= '0;
            i_data_q   <= '0;
            d_dout_q   <= '0;
            i_ack_q    <= 1'b0;
            i_err_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
`ifndef ARB_DPRIO_EN
            last_d_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            gnt_d_q    <= gnt_d_d;
            is_wr_q    <= is_wr_d;
            c_we_q     <= c_we_d;
            c_rreq_q   <= c_rreq_d;
            c_addr_q   <= c_addr_d;
            c_din_q    <= c_din_d;
            i_data_q   <= i_data_d;
            d_dout_q   <= d_dout_d;
            i_ack_q    <= i_ack_d;
            i_err_q    <= i_err_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
`ifndef ARB_DPRIO_EN
            last_d_q   <= last_d_d;
`endif
        end
    end

    assign I_DATA = i_data_q;
    assign I_ACK  = i_ack_q;
    assign I_ERR  = i_err_q;
    assign D_DOUT = d_dout_q;
    assign D_ACK  = d_ack_q;
    assign D_ERR  = d_err_q;
    assign C_ADDR = c_addr_q;
    assign C_DIN  = c_din_q;
    assign C_WE   = c_we_q;
    assign C_RREQ = c_rreq_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;

    logic        CLK, RST;
    logic        I_REQ, D_RREQ, D_WE, C_RDY;
    logic [31:0] I_ADDR, D_ADDR, D_DIN;
    logic [31:0] I_DATA, D_DOUT, C_ADDR, C_DIN, C_DOUT;
    logic        I_ACK, I_ERR, D_ACK, D_ERR, C_WE, C_RREQ;
    logic [31:0] cdout_base;

    int n_checks = 0;
    int n_fail   = 0;

    int          a_cyc, r_n, w_n;
    logic        s_i, s_d, e_v, st_v;
    logic [31:0] a_s, d_s;

    cache_arbiter #(.ADDR_W(32), .DATA_W(32), .HOLD_CYC(2), .TMO_CYC(8)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_DATA(I_DATA), .I_ACK(I_ACK), .I_ERR(I_ERR),
        .D_RREQ(D_RREQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_DIN(D_DIN),
        .D_DOUT(D_DOUT), .D_ACK(D_ACK), .D_ERR(D_ERR),
        .C_ADDR(C_ADDR), .C_DIN(C_DIN), .C_WE(C_WE), .C_RREQ(C_RREQ),
        .C_DOUT(C_DOUT), .C_RDY(C_RDY)
    );

    // cache model: read data is a base value plus the presented address
    assign C_DOUT = cdout_base + C_ADDR;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // called at the negedge where the request was applied (cycle 1); stops at the ACK cycle
    task automatic observe(input int max_cyc, input int drop_at,
                           output int ack_cyc, output int rreq_n, output int we_n,
                           output logic saw_i, output logic saw_d, output logic err_v,
                           output logic [31:0] addr_s, output logic [31:0] din_s,
                           output logic stable);
        ack_cyc = 0; rreq_n = 0; we_n = 0; saw_i = 0; saw_d = 0; err_v = 0;
        addr_s = '0; din_s = '0; stable = 1'b1;
        for (int k = 2; k <= max_cyc; k++) begin
            @(negedge CLK);
            if (k == drop_at) begin
                I_REQ = 0; D_RREQ = 0; D_WE = 0; I_ADDR = 32'h9; D_ADDR = 32'h9;
            end
            if (C_RREQ === 1'b1) rreq_n++;
            if (C_WE === 1'b1) we_n++;
            if (C_RREQ === 1'b1 || C_WE === 1'b1) begin
                if (rreq_n + we_n == 1) begin
                    addr_s = C_ADDR; din_s = C_DIN;
                end else if (C_ADDR !== addr_s || C_DIN !== din_s) begin
                    stable = 1'b0;
                end
            end
            if (I_ACK === 1'b1 || D_ACK === 1'b1) begin
                ack_cyc = k; saw_i = I_ACK; saw_d = D_ACK; err_v = I_ERR | D_ERR;
                I_REQ = 0; D_RREQ = 0; D_WE = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge CLK);
        n_checks++;
        if ({C_WE, C_RREQ, I_ACK, D_ACK, I_ERR, D_ERR, C_ADDR, C_DIN, I_DATA, D_DOUT} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b rreq=%b iack=%b dack=%b ierr=%b derr=%b addr=%h din=%h idata=%h ddout=%h required all zero",
                     C_WE, C_RREQ, I_ACK, D_ACK, I_ERR, D_ERR, C_ADDR, C_DIN, I_DATA, D_DOUT);
        end
        RST = 1;
    endtask

    task automatic test_read;
        @(negedge CLK);
        cdout_base = 32'h53; C_RDY = 1; I_REQ = 1; I_ADDR = 32'd2;
        observe(20, 0, a_cyc, r_n, w_n, s_i, s_d, e_v, a_s, d_s, st_v);
        n_checks++; if (a_cyc !== 5) begin n_fail++; $display("FAIL read_latency: got %0d required 5", a_cyc); end
        n_checks++; if ({s_i, s_d} !== 2'b10) begin n_fail++; $display("FAIL read_ack_port: got i=%b d=%b required i=1 d=0", s_i, s_d); end
        n_checks++; if (r_n !== 2 || w_n !== 0) begin n_fail++; $display("FAIL read_strobe: got rreq=%0d we=%0d required 2/0", r_n, w_n); end
        n_checks++; if (a_s !== 32'd2 || !st_v) begin n_fail++; $display("FAIL read_addr: got %h stable=%b required 2 stable=1", a_s, st_v); end
        n_checks++; if (I_DATA !== 32'h55) begin n_fail++; $display("FAIL read_data: got %h required 55", I_DATA); end
        n_checks++; if (e_v !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b required 0", e_v); end
        @(negedge CLK);
        n_checks++; if (I_ACK !== 1'b0) begin n_fail++; $display("FAIL read_ack_width: got %b required 0", I_ACK); end
    endtask

    task automatic test_write;
        @(negedge CLK);
        D_WE = 1; D_ADDR = 32'd22; D_DIN = 32'hFFFFE8CA;
        observe(20, 0, a_cyc, r_n, w_n, s_i, s_d, e_v, a_s, d_s, st_v);
        n_checks++; if (a_cyc !== 5 || s_d !== 1'b1) begin n_fail++; $display("FAIL write_ack: got cyc=%0d d=%b required 5/1", a_cyc, s_d); end
        n_checks++; if (w_n !== 2 || r_n !== 0) begin n_fail++; $display("FAIL write_strobe: got we=%0d rreq=%0d required 2/0", w_n, r_n); end
        n_checks++; if (a_s !== 32'd22 || d_s !== 32'hFFFFE8CA || !st_v) begin n_fail++; $display("FAIL write_addr_data: got %h/%h stable=%b required 16/ffffe8ca", a_s, d_s, st_v); end
        n_checks++; if (D_DOUT !== 32'h0) begin n_fail++; $display("FAIL write_dout_held: got %h required 0", D_DOUT); end
    endtask

    task automatic test_both;
        @(negedge CLK);
        D_WE = 1; D_RREQ = 1; D_ADDR = 32'd7; D_DIN = 32'h1234;
        observe(20, 0, a_cyc, r_n, w_n, s_i, s_d, e_v, a_s, d_s, st_v);
        n_checks++; if (w_n !== 2 || r_n !== 0) begin n_fail++; $display("FAIL both_as_write: got we=%0d rreq=%0d required 2/0", w_n, r_n); end
        n_checks++; if (s_d !== 1'b1 || a_s !== 32'd7) begin n_fail++; $display("FAIL both_ack: got d=%b addr=%h required 1/7", s_d, a_s); end
    endtask

    task automatic test_early_drop;
        @(negedge CLK);
        D_RREQ = 1; D_ADDR = 32'd3;
        observe(20, 2, a_cyc, r_n, w_n, s_i, s_d, e_v, a_s, d_s, st_v);
        n_checks++; if (a_cyc !== 5 || s_d !== 1'b1) begin n_fail++; $display("FAIL drop_ack: got cyc=%0d d=%b required 5/1", a_cyc, s_d); end
        n_checks++; if (a_s !== 32'd3 || !st_v) begin n_fail++; $display("FAIL drop_addr_held: got %h stable=%b required 3", a_s, st_v); end
        n_checks++; if (D_DOUT !== 32'h56) begin n_fail++; $display("FAIL drop_data: got %h required 56", D_DOUT); end
    endtask

    task automatic test_timeout;
        @(negedge CLK);
        C_RDY = 0; cdout_base = 32'h999; D_RREQ = 1; D_ADDR = 32'd4;
        observe(30, 0, a_cyc, r_n, w_n, s_i, s_d, e_v, a_s, d_s, st_v);
        n_checks++; if (a_cyc !== 12 || s_d !== 1'b1) begin n_fail++; $display("FAIL tmo_ack: got cyc=%0d d=%b required 12/1", a_cyc, s_d); end
        n_checks++; if (D_ERR !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b required 1", D_ERR); end
        n_checks++; if (D_DOUT !== 32'h56) begin n_fail++; $display("FAIL tmo_dout_held: got %h required 56", D_DOUT); end
        @(negedge CLK);
        n_checks++; if ({D_ACK, D_ERR, C_RREQ, C_WE} !== 4'b0) begin n_fail++; $display("FAIL tmo_after: got ack=%b err=%b rreq=%b we=%b required 0", D_ACK, D_ERR, C_RREQ, C_WE); end
        C_RDY = 1;
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_g;
        logic [3:0] g;
        int         t[4];
        int         n;
        int         both_n;
`ifdef ARB_DPRIO_EN
        exp_g = 4'b1111;
`else
        exp_g = 4'b0101;
`endif
        g = '0; n = 0; both_n = 0;
        @(negedge CLK);
        RST = 0;
        @(negedge CLK);
        RST = 1; cdout_base = 32'h100; C_RDY = 1;
        I_REQ = 1; I_ADDR = 32'h10; D_RREQ = 1; D_ADDR = 32'h20;
        for (int k = 2; k <= 40; k++) begin
            @(negedge CLK);
            if (I_ACK === 1'b1 && D_ACK === 1'b1) both_n++;
            if (I_ACK === 1'b1 || D_ACK === 1'b1) begin
                g[n] = D_ACK; t[n] = k;
                n_checks++;
                if (D_ACK === 1'b1 && D_DOUT !== 32'h120) begin n_fail++; $display("FAIL rr_ddata: got %h required 120", D_DOUT); end
                else if (I_ACK === 1'b1 && I_DATA !== 32'h110) begin n_fail++; $display("FAIL rr_idata: got %h required 110", I_DATA); end
                n++;
                if (n == 4) begin
                    I_REQ = 0; D_RREQ = 0;
                    break;
                end
            end
        end
        I_REQ = 0; D_RREQ = 0;
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL rr_count: got %0d acks required 4", n); end
        n_checks++; if (g !== exp_g) begin n_fail++; $display("FAIL rr_order: got %b required %b (bit0 first, 1=D)", g, exp_g); end
        n_checks++; if (both_n !== 0) begin n_fail++; $display("FAIL rr_dual_ack: got %0d required 0", both_n); end
        if (n == 4) begin
            n_checks++;
            if (t[0] !== 5 || t[1] !== 10 || t[2] !== 15 || t[3] !== 20) begin
                n_fail++; $display("FAIL rr_spacing: got %0d %0d %0d %0d required 5 10 15 20", t[0], t[1], t[2], t[3]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acks;
        @(negedge CLK);
        C_RDY = 0; D_RREQ = 1; D_ADDR = 32'd6; D_DIN = 32'hABCD;
        repeat (3) @(negedge CLK);
        RST = 0; D_RREQ = 0;
        @(negedge CLK);
        n_checks++;
        if ({C_WE, C_RREQ, I_ACK, D_ACK, I_ERR, D_ERR, C_ADDR, C_DIN, I_DATA, D_DOUT} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got we=%b rreq=%b ack=%b%b err=%b%b addr=%h din=%h idata=%h ddout=%h required all zero",
                     C_WE, C_RREQ, I_ACK, D_ACK, I_ERR, D_ERR, C_ADDR, C_DIN, I_DATA, D_DOUT);
        end
        RST = 1; C_RDY = 1;
        acks = 0;
        repeat (20) begin
            @(negedge CLK);
            if (I_ACK === 1'b1 || D_ACK === 1'b1) acks++;
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL midreset_no_ack: got %0d required 0", acks); end
        cdout_base = 32'h53; I_REQ = 1; I_ADDR = 32'd2;
        observe(20, 0, a_cyc, r_n, w_n, s_i, s_d, e_v, a_s, d_s, st_v);
        n_checks++; if (a_cyc !== 5 || s_i !== 1'b1 || I_DATA !== 32'h55) begin n_fail++; $display("FAIL midreset_fresh: got cyc=%0d i=%b data=%h required 5/1/55", a_cyc, s_i, I_DATA); end
    endtask

    initial begin
        RST = 0; I_REQ = 0; D_RREQ = 0; D_WE = 0; C_RDY = 0;
        I_ADDR = '0; D_ADDR = '0; D_DIN = '0; cdout_base = '0;
        test_reset;
        test_read;
        test_write;
        test_both;
        test_early_drop;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
